axi_lite_gpio_mc: RTL and testbench



---
 rtl/axi_lite_gpio_mc.sv | 211 +++++++++++++++++++++
 tb/tb_axi_lite_gpio_mc.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_gpio_mc.sv
// Multi-bank AXI-lite GPIO: independent read/write slave FSMs, input synchroniser,
// per-pin rising/falling edge interrupts with W1C status and atomic SET/CLR.
module axi_lite_gpio_mc #(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          GPIO_WIDTH    = 32,
    parameter int          CHANNELS      = 2,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [31:0] TRI_DEFAULT   = 32'hFFFFFFFF
) (
    input  logic                              aclk,
    input  logic                              arst,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [ADDRESS_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    input  logic [31:0]                       s_axi_wdata,
    input  logic [3:0]                        s_axi_wstrb,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    output logic [1:0]                        s_axi_bresp,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    input  logic [ADDRESS_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic [31:0]                       s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              irq,
    input  logic [CHANNELS*GPIO_WIDTH-1:0]    gpio_io_i,
    output logic [CHANNELS*GPIO_WIDTH-1:0]    gpio_io_o,
    output logic [CHANNELS*GPIO_WIDTH-1:0]    gpio_io_t
);
    localparam int NP = CHANNELS * GPIO_WIDTH;
    localparam logic [0:0] W_IDLE = 1'b0, W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0, R_RESP = 1'b1;
    localparam logic [2:0] REG_DIN = 3'd0, REG_DOUT = 3'd1, REG_TRI = 3'd2, REG_RISE = 3'd3,
                           REG_FALL = 3'd4, REG_STAT = 3'd5, REG_SET = 3'd6, REG_CLR = 3'd7;

    logic [0:0]            w_state, r_state;
    logic [GPIO_WIDTH-1:0] data_out [CHANNELS], data_out_d [CHANNELS];
    logic [GPIO_WIDTH-1:0] tri_q    [CHANNELS], tri_d      [CHANNELS];
    logic [GPIO_WIDTH-1:0] rise_en  [CHANNELS], rise_d     [CHANNELS];
    logic [GPIO_WIDTH-1:0] fall_en  [CHANNELS], fall_d     [CHANNELS];
    logic [GPIO_WIDTH-1:0] status   [CHANNELS], status_d   [CHANNELS];
    logic [GPIO_WIDTH-1:0] w1c      [CHANNELS];
    logic                  gie, any_status;
    logic [NP-1:0]         sync_q [SYNC_STAGES];
    logic [NP-1:0]         prev_q, sync_now, rise, fall;
    logic                  do_write, wr_gie, wr_chan, rd_gie, rd_chan;
    logic [31:0]           lane, wbits, rd_val;
    logic                  unused;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Only the first 256 bytes of the window decode; anything above is unmapped.
    function automatic logic page_zero(input logic [ADDRESS_WIDTH-1:0] addr);
        return (addr >> 8) == '0;
    endfunction

    assign unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign wr_gie  = page_zero(s_axi_awaddr) && (s_axi_awaddr[7:2] == 6'h20);
    assign wr_chan = page_zero(s_axi_awaddr) && !s_axi_awaddr[7] && (int'(s_axi_awaddr[6:5]) < CHANNELS);
    assign rd_gie  = page_zero(s_axi_araddr) && (s_axi_araddr[7:2] == 6'h20);
    assign rd_chan = page_zero(s_axi_araddr) && !s_axi_araddr[7] && (int'(s_axi_araddr[6:5]) < CHANNELS);

    // Address and data are only taken together, and only from idle.
    assign s_axi_awready = !arst && (w_state == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign s_axi_wready  = s_axi_awready;
    assign s_axi_arready = !arst && (r_state == R_IDLE) && s_axi_arvalid;
    assign do_write      = s_axi_awready;

    assign lane     = strb_mask(s_axi_wstrb);
    assign wbits    = s_axi_wdata & lane;
    assign sync_now = sync_q[SYNC_STAGES-1];
    assign rise     = sync_now & ~prev_q;
    assign fall     = ~sync_now & prev_q;

    always_comb begin
        any_status = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            data_out_d[c] = data_out[c];
            tri_d[c]      = tri_q[c];
            rise_d[c]     = rise_en[c];
            fall_d[c]     = fall_en[c];
            w1c[c]        = '0;
            if (do_write && wr_chan && (s_axi_awaddr[6:5] == 2'(c))) begin
                case (s_axi_awaddr[4:2])
                    REG_DOUT: data_out_d[c] = (data_out[c] & ~lane[GPIO_WIDTH-1:0]) | wbits[GPIO_WIDTH-1:0];
                    REG_TRI:  tri_d[c]      = (tri_q[c] & ~lane[GPIO_WIDTH-1:0]) | wbits[GPIO_WIDTH-1:0];
                    REG_RISE: rise_d[c]     = (rise_en[c] & ~lane[GPIO_WIDTH-1:0]) | wbits[GPIO_WIDTH-1:0];
                    REG_FALL: fall_d[c]     = (fall_en[c] & ~lane[GPIO_WIDTH-1:0]) | wbits[GPIO_WIDTH-1:0];
                    REG_STAT: w1c[c]        = wbits[GPIO_WIDTH-1:0];
                    REG_SET:  data_out_d[c] = data_out[c] | wbits[GPIO_WIDTH-1:0];
                    REG_CLR:  data_out_d[c] = data_out[c] & ~wbits[GPIO_WIDTH-1:0];
                    default:  ;
                endcase
            end
            // New edges are OR-ed in after the clear so they win over a same-cycle W1C.
            status_d[c] = (status[c] & ~w1c[c])
                        | (rise[c*GPIO_WIDTH +: GPIO_WIDTH] & rise_en[c])
                        | (fall[c*GPIO_WIDTH +: GPIO_WIDTH] & fall_en[c]);
            any_status  = any_status | (|status[c]);
        end
    end

    always_comb begin
        rd_val = '0;
        if (rd_gie) rd_val[0] = gie;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_chan && (s_axi_araddr[6:5] == 2'(c))) begin
                case (s_axi_araddr[4:2])
                    REG_DIN:  rd_val[GPIO_WIDTH-1:0] = sync_now[c*GPIO_WIDTH +: GPIO_WIDTH];
                    REG_DOUT: rd_val[GPIO_WIDTH-1:0] = data_out[c];
                    REG_TRI:  rd_val[GPIO_WIDTH-1:0] = tri_q[c];
                    REG_RISE: rd_val[GPIO_WIDTH-1:0] = rise_en[c];
                    REG_FALL: rd_val[GPIO_WIDTH-1:0] = fall_en[c];
                    REG_STAT: rd_val[GPIO_WIDTH-1:0] = status[c];
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_io_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_now;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                data_out[c] <= '0;
                tri_q[c]    <= TRI_DEFAULT[GPIO_WIDTH-1:0];
                rise_en[c]  <= '0;
                fall_en[c]  <= '0;
                status[c]   <= '0;
            end
            gie <= 1'b0;
            irq <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                data_out[c] <= data_out_d[c];
                tri_q[c]    <= tri_d[c];
                rise_en[c]  <= rise_d[c];
                fall_en[c]  <= fall_d[c];
                status[c]   <= status_d[c];
            end
            if (do_write && wr_gie && s_axi_wstrb[0]) gie <= s_axi_wdata[0];
            irq <= gie && any_status;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            w_state      <= W_IDLE;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: if (do_write) begin
                    w_state      <= W_RESP;
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= (wr_gie || wr_chan) ? 2'b00 : 2'b10;
                end
                W_RESP: if (s_axi_bready) begin
                    w_state      <= W_IDLE;
                    s_axi_bvalid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state      <= R_IDLE;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= 2'b00;
            s_axi_rdata  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (s_axi_arready) begin
                    r_state      <= R_RESP;
                    s_axi_rvalid <= 1'b1;
                    s_axi_rdata  <= rd_val;
                    s_axi_rresp  <= (rd_gie || rd_chan) ? 2'b00 : 2'b10;
                end
                R_RESP: if (s_axi_rready) begin
                    r_state      <= R_IDLE;
                    s_axi_rvalid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_pads
        assign gpio_io_o[c*GPIO_WIDTH +: GPIO_WIDTH] = data_out[c];
        assign gpio_io_t[c*GPIO_WIDTH +: GPIO_WIDTH] = tri_q[c];
    end
endmodule

// File: tb/tb_axi_lite_gpio_mc.sv
// Scoreboard bench for axi_lite_gpio_mc: a register-level model predicts each AXI
// response; a monitor pops and compares whenever a B or R handshake occurs.
module tb_axi_lite_gpio_mc;
    localparam int          AW      = 32;
    localparam int          GW      = 32;
    localparam int          CH      = 2;
    localparam int          SS      = 2;
    localparam logic [31:0] TRI_DEF = 32'hFFFFFFFF;

    logic aclk = 1'b0;
    logic arst = 1'b1;
    always #5 aclk = ~aclk;

    logic          awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [2:0]    awprot = '0, arprot = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [CH*GW-1:0] gpio_io_i = '0;
    logic [CH*GW-1:0] gpio_io_o, gpio_io_t;

    axi_lite_gpio_mc #(.ADDRESS_WIDTH(AW), .GPIO_WIDTH(GW), .CHANNELS(CH),
                       .SYNC_STAGES(SS), .TRI_DEFAULT(TRI_DEF)) dut (
        .aclk(aclk), .arst(arst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .irq(irq), .gpio_io_i(gpio_io_i), .gpio_io_o(gpio_io_o), .gpio_io_t(gpio_io_t)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [CH*GW-1:0] o_snap;
    logic        irq_snap;

    logic [31:0] m_out[CH], m_tri[CH], m_rise[CH], m_fall[CH], m_stat[CH];
    logic        m_gie;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: got no handshake, expected one within the cycle bound", nm);
    endtask

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int c = 0; c < CH; c++) begin
            m_out[c] = 0; m_tri[c] = TRI_DEF; m_rise[c] = 0; m_fall[c] = 0; m_stat[c] = 0;
        end
        m_gie = 0;
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m = 0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    function automatic bit m_dec(input logic [31:0] a, output int ch, output int r, output bit g);
        g = 0; ch = 0; r = 0;
        if (a >= 32'h100) return 0;
        if (a[7:2] == 6'h20) begin g = 1; return 1; end
        if (a >= 32'h80) return 0;
        ch = int'(a / 32);
        r  = int'((a % 32) / 4);
        return ch < CH;
    endfunction

    function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int ch, r; bit g;
        logic [31:0] lane, wb;
        lane = bmask(s);
        wb   = d & lane;
        if (!m_dec(a, ch, r, g)) return 2'b10;
        if (g) begin
            if (s[0]) m_gie = d[0];
            return 2'b00;
        end
        case (r)
            1: m_out[ch]  = (m_out[ch] & ~lane) | wb;
            2: m_tri[ch]  = (m_tri[ch] & ~lane) | wb;
            3: m_rise[ch] = (m_rise[ch] & ~lane) | wb;
            4: m_fall[ch] = (m_fall[ch] & ~lane) | wb;
            5: m_stat[ch] = m_stat[ch] & ~wb;
            6: m_out[ch]  = m_out[ch] | wb;
            7: m_out[ch]  = m_out[ch] & ~wb;
            default: ;
        endcase
        return 2'b00;
    endfunction

    function automatic logic [33:0] m_read(input logic [31:0] a);
        int ch, r; bit g;
        logic [31:0] v;
        if (!m_dec(a, ch, r, g)) return {2'b10, 32'h0};
        if (g) return {2'b00, 31'h0, m_gie};
        case (r)
            0: v = gpio_io_i[ch*GW +: GW];
            1: v = m_out[ch];
            2: v = m_tri[ch];
            3: v = m_rise[ch];
            4: v = m_fall[ch];
            5: v = m_stat[ch];
            default: v = 0;
        endcase
        return {2'b00, v};
    endfunction

    function automatic void m_edge(input logic [CH*GW-1:0] oldp, input logic [CH*GW-1:0] newp);
        logic [31:0] r, f;
        for (int c = 0; c < CH; c++) begin
            r = newp[c*GW +: GW] & ~oldp[c*GW +: GW];
            f = ~newp[c*GW +: GW] & oldp[c*GW +: GW];
            m_stat[c] = m_stat[c] | (r & m_rise[c]) | (f & m_fall[c]);
        end
    endfunction

    function automatic logic m_irq();
        logic any = 0;
        for (int c = 0; c < CH; c++) any = any | (|m_stat[c]);
        return m_gie & any;
    endfunction

    // ---------------- bus driver tasks ----------------
    task automatic set_pins(input logic [CH*GW-1:0] np);
        m_edge(gpio_io_i, np);
        gpio_io_i = np;
    endtask

    task automatic aw_drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_b.push_back(m_write(a, d, s));
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1;
    endtask

    task automatic aw_wait_hs();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk);
            if (awready && wready) begin
                got = 1;
                @(posedge aclk); #1;
                o_snap = gpio_io_o;
                irq_snap = irq;
            end
        end
        awvalid = 0; wvalid = 0;
        if (!got) tmo("aw_handshake");
    endtask

    task automatic b_wait();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk);
            if (bvalid && bready) begin
                got = 1;
                @(posedge aclk); #1;
            end
        end
        if (!got) tmo("b_handshake");
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        aw_drive(a, d, s);
        aw_wait_hs();
        b_wait();
    endtask

    task automatic ar_drive(input logic [31:0] a);
        exp_r.push_back(m_read(a));
        araddr = a;
        arvalid = 1;
    endtask

    task automatic ar_wait_hs();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk);
            if (arready) begin
                got = 1;
                @(posedge aclk); #1;
            end
        end
        arvalid = 0;
        if (!got) tmo("ar_handshake");
    endtask

    task automatic r_wait();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk);
            if (rvalid && rready) begin
                got = 1;
                @(posedge aclk); #1;
            end
        end
        if (!got) tmo("r_handshake");
    endtask

    task automatic rd(input logic [31:0] a);
        ar_drive(a);
        ar_wait_hs();
        r_wait();
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge aclk);
            if (bvalid && bready) begin
                if (exp_b.size() == 0) chk("bresp_unexpected", {62'h0, bresp}, 64'hDEAD);
                else chk("bresp", {62'h0, bresp}, {62'h0, exp_b.pop_front()});
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) chk("rresp_rdata_unexpected", {30'h0, rresp, rdata}, 64'hDEAD);
                else chk("rresp_rdata", {30'h0, rresp, rdata}, {30'h0, exp_r.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int bad_bv, bad_aw;
        bit dropped;
        logic [31:0] a;
        int sel;
        m_reset();
        @(posedge aclk); #1;
        chk("reset_valids", {59'h0, awready, wready, bvalid, arready, rvalid}, 64'h0);
        @(posedge aclk); #1;
        arst = 0;
        chk("reset_tri", gpio_io_t, {CH*GW{1'b1}});
        chk("reset_out", gpio_io_o, 64'h0);
        chk("reset_irq", irq, 0);
        chk("reset_resp", {30'h0, bresp, rresp, rdata}, 64'h0);
        rd(32'h08);

        // Byte-lane write, then atomic SET and CLR on channel 1
        wr(32'h24, 32'hA5A5A5A5, 4'b0011);
        chk("dout_after_hs", o_snap[63:32], 32'h0000A5A5);
        wr(32'h38, 32'h00FF0000, 4'hF);
        chk("set_ch1", gpio_io_o[63:32], 32'h00FFA5A5);
        wr(32'h3C, 32'h000000A5, 4'hF);
        chk("clr_ch1", gpio_io_o[63:32], 32'h00FFA500);
        rd(32'h24);
        rd(32'h38);

        // Rising-edge interrupt on pin 0
        wr(32'h0C, 32'h1, 4'hF);
        wr(32'h80, 32'h1, 4'hF);
        set_pins(gpio_io_i | 64'h1);
        repeat (SS + 1) @(posedge aclk);
        #1 chk("irq_not_early", irq, 0);
        @(posedge aclk);
        #1 chk("irq_rise", irq, 1);
        rd(32'h14);
        rd(32'h00);
        wr(32'h14, 32'h1, 4'hF);
        chk("irq_at_w1c_hs", irq_snap, 1);
        chk("irq_after_w1c", irq, 0);

        // Falling edge on pin 3 coincident with a W1C of bit 3
        wr(32'h10, 32'h8, 4'hF);
        set_pins(gpio_io_i | 64'h8);
        repeat (SS + 3) @(posedge aclk);
        #1 set_pins(gpio_io_i & ~64'h8);
        repeat (SS + 3) @(posedge aclk);
        #1 chk("irq_fall", irq, 1);
        set_pins(gpio_io_i | 64'h8);
        repeat (SS + 3) @(posedge aclk);
        #1 set_pins(gpio_io_i & ~64'h8);
        repeat (SS) @(posedge aclk);
        #1;
        dropped = 0;
        fork
            wr(32'h14, 32'h8, 4'hF);
            begin
                repeat (SS + 4) begin
                    @(posedge aclk); #1;
                    if (!irq) dropped = 1;
                end
            end
        join
        // The edge landed in the same cycle as the clear, so the set wins.
        m_stat[0] = m_stat[0] | (32'h8 & m_fall[0]);
        chk("irq_held_set_priority", dropped, 0);
        rd(32'h14);
        wr(32'h14, 32'h8, 4'hF);
        chk("irq_after_plain_w1c", irq, m_irq());

        // Backpressure: response held, second write stalled
        bready = 0;
        aw_drive(32'h04, 32'h00001234, 4'hF);
        aw_wait_hs();
        aw_drive(32'h04, 32'h00005678, 4'hF);
        bad_bv = 0; bad_aw = 0;
        repeat (5) begin
            @(negedge aclk);
            if (!bvalid) bad_bv++;
            if (awready) bad_aw++;
        end
        chk("bp_bvalid_held", bad_bv, 0);
        chk("bp_awready_low", bad_aw, 0);
        @(posedge aclk); #1;
        bready = 1;
        b_wait();
        aw_wait_hs();
        b_wait();
        chk("bp_second_write", gpio_io_o[31:0], m_out[0]);
        rd(32'h40);
        wr(32'h44, 32'hFFFFFFFF, 4'hF);

        // Randomised register traffic against the model with static pins
        wr(32'h0C, 0, 4'hF); wr(32'h10, 0, 4'hF);
        wr(32'h2C, 0, 4'hF); wr(32'h30, 0, 4'hF);
        set_pins({$urandom, $urandom});
        repeat (SS + 3) @(posedge aclk);
        #1;
        wr(32'h14, 32'hFFFFFFFF, 4'hF);
        wr(32'h34, 32'hFFFFFFFF, 4'hF);
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) a = $urandom_range(0, 3) * 32 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
            else if (sel == 8) a = 32'h80 + $urandom_range(0, 3);
            else begin
                case ($urandom_range(0, 2))
                    0: a = 32'h84;
                    1: a = 32'hC0;
                    default: a = 32'h1000;
                endcase
            end
            if ($urandom_range(0, 1) == 1) wr(a, $urandom, 4'($urandom_range(0, 15)));
            else rd(a);
        end
        chk("rand_out", gpio_io_o, {m_out[1], m_out[0]});
        chk("rand_tri", gpio_io_t, {m_tri[1], m_tri[0]});
        chk("rand_irq", irq, m_irq());

        // Reset while a read response is stalled
        wr(32'h80, 32'h1, 4'hF);
        rready = 0;
        ar_drive(32'h80);
        ar_wait_hs();
        dropped = 1;
        for (int i = 0; i < 20 && dropped; i++) begin
            @(negedge aclk);
            if (rvalid) dropped = 0;
        end
        if (dropped) tmo("rvalid_before_reset");
        @(posedge aclk); #1;
        arst = 1;
        @(posedge aclk); #1;
        chk("rvalid_dropped_by_reset", rvalid, 0);
        exp_r.delete();
        m_reset();
        @(posedge aclk); #1;
        arst = 0;
        rready = 1;
        rd(32'h80);
        chk("post_reset_tri", gpio_io_t, {CH*GW{1'b1}});

        repeat (4) @(posedge aclk);
        #1;
        chk("pending_b", exp_b.size(), 0);
        chk("pending_r", exp_r.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
